register_bank_s12: RTL and testbench

Parametrised multi-entry successor to the single register flip-flop: a bank of `NrOfRegs` registers, each `NrOfBits` wide, sharing one clock. It has one qualified write/modify port, one tri-stateable read port for the shared CPU data bus and one always-driven read port. Per-cycle operations are load, increment, decrement and preset. Registered Carry and Zero status is provided for the CPU sequencer.

---
 rtl/register_bank_s12.sv | 132 +++++++++++++
 tb/tb_register_bank_s12.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_s12.sv
// register_bank_s12: bank of NrOfRegs registers, NrOfBits wide each, with one
// qualified write/modify port (load, increment, decrement, preset), a
// tri-stateable bus read port (QA) and an always-driven side read port (QB).
// Registered Carry/Zero status reflects the last qualified write.
//
// Ports:
//   Clock, Reset (async, active-low)
//   ClockEnable, Tick, WrEn          - update qualifiers
//   Op[1:0]                          - 00 load, 01 inc, 10 dec, 11 preset
//   WrAddr, WrData                   - write target / load data
//   RdAddrA, cs, QA                  - bus read, QA high-Z while cs=1
//   RdAddrB, QB                      - side read, always driven
//   Carry, Zero                      - registered status
//
// Optional build macro: REGBANK_BYPASS_EN
//   defined   - reads of the register being written return the pending result
//   undefined - reads always return the stored value
module register_bank_s12 #(
    parameter int unsigned NrOfBits     = 8,
    parameter int unsigned NrOfRegs     = 8,
    parameter int unsigned NrOfAddrBits = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ClockEnable,
    input  logic                    Tick,
    input  logic                    WrEn,
    input  logic [1:0]              Op,
    input  logic [NrOfAddrBits-1:0] WrAddr,
    input  logic [NrOfBits-1:0]     WrData,
    input  logic [NrOfAddrBits-1:0] RdAddrA,
    input  logic                    cs,
    output logic [NrOfBits-1:0]     QA,
    input  logic [NrOfAddrBits-1:0] RdAddrB,
    output logic [NrOfBits-1:0]     QB,
    output logic                    Carry,
    output logic                    Zero
);

    localparam int unsigned W  = NrOfBits;
    localparam int unsigned AW = NrOfAddrBits;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_INC    = 2'b01,
        OP_DEC    = 2'b10,
        OP_PRESET = 2'b11
    } op_e;

    logic [W-1:0] bank_q [NrOfRegs];
    logic [W-1:0] bank_d [NrOfRegs];
    logic         carry_q, carry_d;
    logic         zero_q,  zero_d;

    logic         upd_c;
    logic [W-1:0] cur_c;
    logic [W-1:0] result_c;
    logic         carry_res_c;
    logic [W-1:0] rd_a_c;
    logic [W-1:0] rd_b_c;

    // Update strobe, selected operand and operation result
    always_comb begin
        upd_c       = ClockEnable & Tick & WrEn & (32'(WrAddr) < 32'(NrOfRegs));
        cur_c       = '0;
        result_c    = '0;
        carry_res_c = 1'b0;
        for (int unsigned i = 0; i < NrOfRegs; i++) begin
            if (WrAddr == AW'(i)) cur_c = bank_q[i];
        end
        case (op_e'(Op))
            OP_LOAD:   result_c = WrData;
            OP_INC: begin
                result_c    = cur_c + W'(1);
                carry_res_c = &cur_c;
            end
            OP_DEC: begin
                result_c    = cur_c - W'(1);
                carry_res_c = ~|cur_c;
            end
            default:   result_c = '1;
        endcase
    end

    // Next state of the bank and status flags
    always_comb begin
        bank_d  = bank_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (upd_c) begin
            for (int unsigned i = 0; i < NrOfRegs; i++) begin
                if (WrAddr == AW'(i)) bank_d[i] = result_c;
            end
            carry_d = carry_res_c;
            zero_d  = ~|result_c;
        end
    end

    // State registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NrOfRegs; i++) bank_q[i] <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            bank_q  <= bank_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // Combinational read ports; out-of-range addresses read zero
    always_comb begin
        rd_a_c = '0;
        rd_b_c = '0;
        for (int unsigned i = 0; i < NrOfRegs; i++) begin
            if (RdAddrA == AW'(i)) rd_a_c = bank_q[i];
            if (RdAddrB == AW'(i)) rd_b_c = bank_q[i];
        end
`ifdef REGBANK_BYPASS_EN
        // Write-through forwarding of the pending result
        if (upd_c && (RdAddrA == WrAddr)) rd_a_c = result_c;
        if (upd_c && (RdAddrB == WrAddr)) rd_b_c = result_c;
`endif
    end

    assign QA    = cs ? {W{1'bz}} : rd_a_c;
    assign QB    = rd_b_c;
    assign Carry = carry_q;
    assign Zero  = zero_q;

endmodule

// File: tb/tb_register_bank_s12.sv
// Randomized scoreboard bench for register_bank_s12 (8-bit, 6 registers).
module tb_register_bank_s12;

    localparam int unsigned NB = 8;
    localparam int unsigned NR = 6;
    localparam int unsigned NA = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          ClockEnable = 1'b0;
    logic          Tick = 1'b0;
    logic          WrEn = 1'b0;
    logic [1:0]    Op = 2'b00;
    logic [NA-1:0] WrAddr = '0;
    logic [NB-1:0] WrData = '0;
    logic [NA-1:0] RdAddrA = '0;
    logic          cs = 1'b1;
    wire  [NB-1:0] QA;
    logic [NA-1:0] RdAddrB = '0;
    logic [NB-1:0] QB;
    logic          Carry;
    logic          Zero;

    register_bank_s12 #(.NrOfBits(NB), .NrOfRegs(NR), .NrOfAddrBits(NA)) dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .WrEn(WrEn), .Op(Op), .WrAddr(WrAddr), .WrData(WrData),
        .RdAddrA(RdAddrA), .cs(cs), .QA(QA), .RdAddrB(RdAddrB), .QB(QB),
        .Carry(Carry), .Zero(Zero)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic         cs;
        logic [7:0]   qa;
        logic [7:0]   qb;
        logic         carry;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    // Reference model: plain arrays and arithmetic
    int   mreg [NR];
    bit   mcarry;
    bit   mzero;

    function automatic int rd_model(input int a);
        return (a < int'(NR)) ? mreg[a] : 0;
    endfunction

    // Drive one cycle of stimulus just after the rising edge, record what the
    // outputs must show before the next edge, then advance the model.
    task automatic issue(input bit rst, input bit ce, input bit tk, input bit we,
                         input int op, input int wa, input int wd,
                         input int ra, input int rb, input bit c);
        exp_t e;
        bit   upd;
        int   res;
        bit   cy;
        @(posedge Clock);
        #1;
        Reset = ~rst; ClockEnable = ce; Tick = tk; WrEn = we;
        Op = 2'(op); WrAddr = 3'(wa); WrData = 8'(wd);
        RdAddrA = 3'(ra); RdAddrB = 3'(rb); cs = c;
        if (rst) begin
            for (int i = 0; i < int'(NR); i++) mreg[i] = 0;
            mcarry = 0;
            mzero  = 1;
        end
        upd = !rst && ce && tk && we && (wa < int'(NR));
        res = 0;
        cy  = 0;
        if (upd) begin
            case (op)
                0: res = wd;
                1: begin res = (mreg[wa] + 1) % 256; cy = (mreg[wa] == 255); end
                2: begin res = (mreg[wa] + 255) % 256; cy = (mreg[wa] == 0); end
                default: res = 255;
            endcase
        end
        e.cs    = c;
        e.qa    = 8'(rd_model(ra));
        e.qb    = 8'(rd_model(rb));
`ifdef REGBANK_BYPASS_EN
        if (upd && ra == wa) e.qa = 8'(res);
        if (upd && rb == wa) e.qb = 8'(res);
`endif
        e.carry = mcarry;
        e.zero  = mzero;
        exp_q.push_back(e);
        if (upd) begin
            mreg[wa] = res;
            mcarry   = cy;
            mzero    = (res == 0);
        end
    endtask

    task automatic wr(input int op, input int wa, input int wd, input int rb);
        issue(0, 1, 1, 1, op, wa, wd, wa, rb, 0);
    endtask

    task automatic rd(input int ra, input int rb, input bit c);
        issue(0, 1, 1, 0, 0, 0, 0, ra, rb, c);
    endtask

    // Monitor: outputs are stable mid-cycle; pop and compare each one
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge Clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (QB !== e.qb) begin
                    bad++;
                    $display("FAIL qb: got %h expected %h at %0t", QB, e.qb, $time);
                end
                total++;
                if (Carry !== e.carry) begin
                    bad++;
                    $display("FAIL carry: got %b expected %b at %0t", Carry, e.carry, $time);
                end
                total++;
                if (Zero !== e.zero) begin
                    bad++;
                    $display("FAIL zero: got %b expected %b at %0t", Zero, e.zero, $time);
                end
                if (!e.cs) begin
                    total++;
                    if (QA !== e.qa) begin
                        bad++;
                        $display("FAIL qa: got %h expected %h at %0t", QA, e.qa, $time);
                    end
                end else if (e.qa != 8'h00) begin
                    // Released bus must not carry the stored value
                    total++;
                    if (QA === e.qa) begin
                        bad++;
                        $display("FAIL qa_hiz: got %h while cs=1 at %0t", QA, $time);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(NR); i++) mreg[i] = 0;
        mcarry = 0;
        mzero  = 1;

        // Reset state
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 5, 3, 0);
        // Load and read, then a blocked write with Tick low
        wr(0, 1, 'h3C, 1);
        rd(1, 1, 0);
        issue(0, 1, 0, 1, 0, 1, 'h55, 1, 1, 0);
        rd(1, 1, 0);
        // Increment wrap
        wr(3, 4, 0, 4);
        wr(1, 4, 0, 4);
        wr(1, 4, 0, 4);
        rd(4, 4, 0);
        // Decrement wrap, then load zero
        wr(2, 0, 0, 0);
        wr(0, 0, 0, 0);
        rd(0, 0, 0);
        // Out-of-range write and read
        wr(0, 7, 'h11, 7);
        rd(7, 7, 0);
        for (int i = 0; i < int'(NR); i++) rd(i, i, 0);
        // Same-cycle read of the register being written
        wr(0, 3, 'h77, 3);
        rd(3, 3, 1);
        rd(3, 3, 0);
        // Async reset mid-run
        wr(0, 2, 'h5A, 2);
        rd(2, 2, 1);
        issue(1, 1, 1, 1, 1, 2, 0, 2, 2, 1);
        rd(2, 2, 0);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            issue(0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0);
        end
        rd(0, 1, 0);
        @(negedge Clock);
        @(negedge Clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
